bmu_exec_unit: RTL and testbench

// - Single-cycle bit-manipulation/ALU execution unit of the core pipeline (RV32 base + Zba/Zbb/Zbp/Zbs subset + CSR write data path).
// - One-hot opcode bus selects the operation. Result and error are registered one clock after a valid request.

---
 rtl/bmu_exec_unit.sv | 115 +++++++++++
 tb/tb_bmu_exec_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bmu_exec_unit.sv
// Single-cycle bit-manipulation / ALU execution unit with a one-clock registered result.
// Build option: define BMU_ZBP_EN to implement packu and gorc; otherwise they report error.
module bmu_exec_unit (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        scan_mode,
  input  logic        valid_in,
  input  logic [21:0] ap,
  input  logic        csr_ren_in,
  input  logic [31:0] csr_rddata_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] result_ff,
  output logic        error
);

  // Control bus layout, MSB first: csr_write,csr_imm,zbb,zbp,zba,zbs, then the 16 ALU ops.
  logic op_csr_write, q_csr_imm, q_zbb, q_zbp, q_zba, q_zbs;
  logic op_land, op_lxor, op_sll, op_sra, op_rol, op_bext, op_sh3add, op_add;
  logic op_slt, op_sub, op_clz, op_cpop, op_siext_h, op_min, op_packu, op_gorc;

  assign {op_csr_write, q_csr_imm, q_zbb, q_zbp, q_zba, q_zbs} = ap[21:16];
  assign {op_land, op_lxor, op_sll, op_sra, op_rol, op_bext, op_sh3add, op_add,
          op_slt, op_sub, op_clz, op_cpop, op_siext_h, op_min, op_packu, op_gorc} = ap[15:0];

  logic unused_scan;
  assign unused_scan = scan_mode ^ q_zbp;

  logic [17:0] ops;
  logic        op_onehot;
  logic        qual_err;
  logic        err_d;
  logic [31:0] result_d;
  logic [31:0] result_q;
  logic        error_q;
  logic [5:0]  clz_cnt;
  logic [5:0]  cpop_cnt;
  logic [63:0] rot_w;
  logic [31:0] gorc_w;

  always_comb begin
    ops       = {op_csr_write, csr_ren_in, ap[15:0]};
    op_onehot = (ops != '0) && ((ops & (ops - 18'd1)) == '0);
    qual_err  = ((op_rol | op_clz | op_cpop | op_siext_h | op_min) & ~q_zbb) |
                (op_bext & ~q_zbs) | (op_sh3add & ~q_zba);
`ifdef BMU_ZBP_EN
    qual_err  = qual_err | ((op_packu | op_gorc) & ~q_zbp);
`else
    qual_err  = qual_err | op_packu | op_gorc;
`endif
    err_d     = !op_onehot || qual_err;
  end

  always_comb begin
    clz_cnt  = 6'd32;
    cpop_cnt = '0;
    for (int i = 0; i < 32; i++) begin
      if (a_in[i]) clz_cnt = 6'(31 - i);
      cpop_cnt = cpop_cnt + {5'b0, a_in[i]};
    end
    rot_w = {a_in, a_in} << b_in[4:0];
  end

  // Each enabled stage ORs every bit with its partner at distance 1/2/4/8/16.
  always_comb begin
    gorc_w = a_in;
`ifdef BMU_ZBP_EN
    if (b_in[0]) gorc_w = gorc_w | ((gorc_w & 32'h5555_5555) << 1)  | ((gorc_w & 32'hAAAA_AAAA) >> 1);
    if (b_in[1]) gorc_w = gorc_w | ((gorc_w & 32'h3333_3333) << 2)  | ((gorc_w & 32'hCCCC_CCCC) >> 2);
    if (b_in[2]) gorc_w = gorc_w | ((gorc_w & 32'h0F0F_0F0F) << 4)  | ((gorc_w & 32'hF0F0_F0F0) >> 4);
    if (b_in[3]) gorc_w = gorc_w | ((gorc_w & 32'h00FF_00FF) << 8)  | ((gorc_w & 32'hFF00_FF00) >> 8);
    if (b_in[4]) gorc_w = gorc_w | ((gorc_w & 32'h0000_FFFF) << 16) | ((gorc_w & 32'hFFFF_0000) >> 16);
`endif
  end

  always_comb begin
    result_d = '0;
    if (op_csr_write)    result_d = q_csr_imm ? b_in : a_in;
    else if (csr_ren_in) result_d = csr_rddata_in;
    else if (op_land)    result_d = q_zbb ? (a_in & ~b_in) : (a_in & b_in);
    else if (op_lxor)    result_d = q_zbb ? ~(a_in ^ b_in) : (a_in ^ b_in);
    else if (op_sll)     result_d = a_in << b_in[4:0];
    else if (op_sra)     result_d = 32'($signed(a_in) >>> b_in[4:0]);
    else if (op_rol)     result_d = rot_w[63:32];
    else if (op_bext)    result_d = {31'b0, a_in[b_in[4:0]]};
    else if (op_sh3add)  result_d = (a_in << 3) + b_in;
    else if (op_add)     result_d = a_in + b_in;
    else if (op_slt)     result_d = {31'b0, $signed(a_in) < $signed(b_in)};
    else if (op_sub)     result_d = a_in - b_in;
    else if (op_clz)     result_d = {26'b0, clz_cnt};
    else if (op_cpop)    result_d = {26'b0, cpop_cnt};
    else if (op_siext_h) result_d = {{16{a_in[15]}}, a_in[15:0]};
    else if (op_min)     result_d = ($signed(a_in) < $signed(b_in)) ? a_in : b_in;
    else if (op_packu)   result_d = {b_in[31:16], a_in[31:16]};
    else if (op_gorc)    result_d = gorc_w;
  end

  // valid_in alone qualifies a request (no back-pressure): a valid request updates both
  // outputs on the next edge; an idle cycle holds the result and clears the error flag.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      result_q <= '0;
      error_q  <= 1'b0;
    end else if (valid_in) begin
      result_q <= err_d ? '0 : result_d;
      error_q  <= err_d;
    end else begin
      error_q  <= 1'b0;
    end
  end

  assign result_ff = result_q;
  assign error     = error_q;

endmodule

// File: tb/tb_bmu_exec_unit.sv
// Testbench for bmu_exec_unit: directed vector table, reset/idle sequences and a
// randomized run against a reference model derived from the operation definitions.
module tb_bmu_exec_unit;

  localparam int CSR_WRITE = 21, CSR_IMM = 20, ZBB = 19, ZBP = 18, ZBA = 17, ZBS = 16;
  localparam int LAND = 15, LXOR = 14, SLL = 13, SRA = 12, ROL = 11, BEXT = 10, SH3ADD = 9;
  localparam int ADD = 8, SLT = 7, SUB = 6, CLZ = 5, CPOP = 4, SIEXT = 3, MIN = 2, PACKU = 1, GORC = 0;

  logic        clk;
  logic        rst_l;
  logic        scan_mode;
  logic        valid_in;
  logic [21:0] ap;
  logic        csr_ren_in;
  logic [31:0] csr_rddata_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] result_ff;
  logic        error;

  int total = 0;
  int bad   = 0;

  bmu_exec_unit dut (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .valid_in(valid_in), .ap(ap),
    .csr_ren_in(csr_ren_in), .csr_rddata_in(csr_rddata_in), .a_in(a_in), .b_in(b_in),
    .result_ff(result_ff), .error(error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [21:0] ap;
    logic        ren;
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    logic        exp_e;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [21:0] bit_of(input int idx);
    return 22'(1) << idx;
  endfunction

  function automatic void add_vec(input string n, input logic [21:0] c, input logic ren,
                                  input logic [31:0] rd, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = n; v.ap = c; v.ren = ren; v.rd = rd; v.a = a; v.b = b; v.exp_r = er; v.exp_e = ee;
    vecs.push_back(v);
  endfunction

  // Reference model: each operation from its arithmetic definition.
  function automatic void model(input logic [21:0] c, input logic ren, input logic [31:0] rd,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    int nops, sh, cnt;
    logic need_zbb, need_zbs, need_zba, need_zbp;
    nops = int'(c[CSR_WRITE]) + int'(ren);
    for (int i = 0; i < 16; i++) nops += int'(c[i]);
    sh = int'(b[4:0]);
    r = 32'h0;
    e = 1'b0;
    need_zbb = c[ROL] | c[CLZ] | c[CPOP] | c[SIEXT] | c[MIN];
    need_zbs = c[BEXT];
    need_zba = c[SH3ADD];
    need_zbp = c[PACKU] | c[GORC];
    if (nops != 1 || (need_zbb && !c[ZBB]) || (need_zbs && !c[ZBS]) || (need_zba && !c[ZBA])) begin
      e = 1'b1;
      return;
    end
`ifdef BMU_ZBP_EN
    if (need_zbp && !c[ZBP]) begin e = 1'b1; return; end
`else
    if (need_zbp) begin e = 1'b1; return; end
`endif
    if (c[CSR_WRITE])  r = c[CSR_IMM] ? b : a;
    else if (ren)      r = rd;
    else if (c[LAND])  r = c[ZBB] ? (a & ~b) : (a & b);
    else if (c[LXOR])  r = c[ZBB] ? ~(a ^ b) : (a ^ b);
    else if (c[SLL])   r = 32'((64'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
    else if (c[SRA])   begin
      for (int i = 0; i < 32; i++) r[i] = (i + sh > 31) ? a[31] : a[i + sh];
    end
    else if (c[ROL])   begin
      for (int i = 0; i < 32; i++) r[(i + sh) % 32] = a[i];
    end
    else if (c[BEXT])  r = (a >> sh) & 32'h1;
    else if (c[SH3ADD]) r = 32'((64'(a) * 64'd8 + 64'(b)) % 64'h1_0000_0000);
    else if (c[ADD])   r = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
    else if (c[SLT])   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    else if (c[SUB])   r = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
    else if (c[CLZ])   begin
      cnt = 0;
      while (cnt < 32 && a[31 - cnt] == 1'b0) cnt++;
      r = 32'(cnt);
    end
    else if (c[CPOP])  begin
      cnt = 0;
      for (int i = 0; i < 32; i++) if (a[i]) cnt++;
      r = 32'(cnt);
    end
    else if (c[SIEXT]) r = (a[15] ? 32'hFFFF_0000 : 32'h0) | (a & 32'h0000_FFFF);
    else if (c[MIN])   r = ($signed(a) <= $signed(b)) ? a : b;
    else if (c[PACKU]) r = (b & 32'hFFFF_0000) | (a >> 16);
    else if (c[GORC])  begin
      // result bit i is the OR of every a[j] whose index differs from i only in enabled bits
      for (int i = 0; i < 32; i++)
        for (int j = 0; j < 32; j++)
          if (((i ^ j) & ~sh & 31) == 0 && a[j]) r[i] = 1'b1;
    end
  endfunction

  task automatic check(input string n, input logic [31:0] exp_r, input logic exp_e);
    total++;
    if (result_ff !== exp_r || error !== exp_e) begin
      bad++;
      $display("FAIL %s: got result=%08h error=%b, want result=%08h error=%b",
               n, result_ff, error, exp_r, exp_e);
    end
  endtask

  // driver: present one cycle of inputs, then sample #1 after the edge
  task automatic drive(input logic v, input logic [21:0] c, input logic ren,
                       input logic [31:0] rd, input logic [31:0] a, input logic [31:0] b);
    valid_in = v; ap = c; csr_ren_in = ren; csr_rddata_in = rd; a_in = a; b_in = b;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] exp_r;
  logic        exp_e;
  logic [31:0] hold_r;

  initial begin
    logic [21:0] c;
    logic        ren, v;
    logic [31:0] rd, a, b;
    int          pick;
    int          op_list[17] = '{CSR_WRITE, LAND, LXOR, SLL, SRA, ROL, BEXT, SH3ADD, ADD,
                                  SLT, SUB, CLZ, CPOP, SIEXT, MIN, PACKU, GORC};

    scan_mode = 1'b0; valid_in = 1'b0; ap = '0; csr_ren_in = 1'b0;
    csr_rddata_in = '0; a_in = '0; b_in = '0;
    rst_l = 1'b0;
    #12;
    check("reset_state", 32'h0, 1'b0);
    rst_l = 1'b1;
    @(posedge clk); #1;

    add_vec("add_wrap",   bit_of(ADD), 0, 0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0);
    add_vec("sub_neg",    bit_of(SUB), 0, 0, 32'd5, 32'd7, 32'hFFFF_FFFE, 0);
    add_vec("clz_15",     bit_of(CLZ) | bit_of(ZBB), 0, 0, 32'h0001_0000, 0, 32'd15, 0);
    add_vec("clz_zero",   bit_of(CLZ) | bit_of(ZBB), 0, 0, 32'h0, 0, 32'd32, 0);
    add_vec("cpop",       bit_of(CPOP) | bit_of(ZBB), 0, 0, 32'hF0F0_000F, 0, 32'd12, 0);
    add_vec("min_neg",    bit_of(MIN) | bit_of(ZBB), 0, 0, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFD, 0);
    add_vec("sra",        bit_of(SRA), 0, 0, 32'h8000_0000, 32'd4, 32'hF800_0000, 0);
    add_vec("rol",        bit_of(ROL) | bit_of(ZBB), 0, 0, 32'h8000_0001, 32'd1, 32'h3, 0);
    add_vec("bext",       bit_of(BEXT) | bit_of(ZBS), 0, 0, 32'h10, 32'd4, 32'h1, 0);
    add_vec("andn",       bit_of(LAND) | bit_of(ZBB), 0, 0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_00F0, 0);
    add_vec("and",        bit_of(LAND), 0, 0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0);
    add_vec("xnor",       bit_of(LXOR) | bit_of(ZBB), 0, 0, 32'h0, 32'h0, 32'hFFFF_FFFF, 0);
    add_vec("sll",        bit_of(SLL), 0, 0, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 0);
    add_vec("sh3add",     bit_of(SH3ADD) | bit_of(ZBA), 0, 0, 32'd1, 32'd2, 32'd10, 0);
    add_vec("slt",        bit_of(SLT), 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
    add_vec("siext_h",    bit_of(SIEXT) | bit_of(ZBB), 0, 0, 32'h1234_8001, 0, 32'hFFFF_8001, 0);
    add_vec("csr_imm",    bit_of(CSR_WRITE) | bit_of(CSR_IMM), 0, 0, 32'd1, 32'd2, 32'd2, 0);
    add_vec("csr_reg",    bit_of(CSR_WRITE), 0, 0, 32'd1, 32'd2, 32'd1, 0);
    add_vec("csr_read",   '0, 1, 32'hDEAD_BEEF, 32'd1, 32'd2, 32'hDEAD_BEEF, 0);
    add_vec("imm_alone",  bit_of(CSR_IMM), 0, 0, 32'd1, 32'd2, 32'h0, 1);
    add_vec("add_sub",    bit_of(ADD) | bit_of(SUB), 0, 0, 32'd1, 32'd2, 32'h0, 1);
    add_vec("clz_no_zbb", bit_of(CLZ), 0, 0, 32'h1, 0, 32'h0, 1);
`ifdef BMU_ZBP_EN
    add_vec("packu",      bit_of(PACKU) | bit_of(ZBP), 0, 0, 32'h1234_5678, 32'hABCD_0000, 32'hABCD_1234, 0);
    add_vec("gorc",       bit_of(GORC) | bit_of(ZBP), 0, 0, 32'h0010_0200, 32'd7, 32'h00FF_FF00, 0);
`else
    add_vec("packu_off",  bit_of(PACKU) | bit_of(ZBP), 0, 0, 32'h1234_5678, 32'hABCD_0000, 32'h0, 1);
    add_vec("gorc_off",   bit_of(GORC) | bit_of(ZBP), 0, 0, 32'h0010_0200, 32'd7, 32'h0, 1);
`endif

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].ap, vecs[i].ren, vecs[i].rd, vecs[i].a, vecs[i].b);
      check(vecs[i].name, vecs[i].exp_r, vecs[i].exp_e);
    end

    // after an error, an idle cycle clears error and keeps the zeroed result
    drive(1'b1, bit_of(ADD) | bit_of(SUB), 0, 0, 32'd9, 32'd9);
    check("err_cycle", 32'h0, 1'b1);
    drive(1'b0, '0, 0, 0, 32'd9, 32'd9);
    check("err_idle", 32'h0, 1'b0);

    // idle holds a good result
    drive(1'b1, bit_of(ADD), 0, 0, 32'd40, 32'd2);
    check("add_42", 32'd42, 1'b0);
    drive(1'b0, bit_of(SUB), 0, 0, 32'd1, 32'd1);
    check("idle_hold", 32'd42, 1'b0);

    // asynchronous reset mid-run, then hold zero until the next valid request
    rst_l = 1'b0;
    #1;
    check("async_reset", 32'h0, 1'b0);
    @(posedge clk); #1;
    rst_l = 1'b1;
    drive(1'b0, bit_of(ADD), 0, 0, 32'd5, 32'd5);
    check("post_reset_idle", 32'h0, 1'b0);
    drive(1'b1, bit_of(ADD), 0, 0, 32'd5, 32'd5);
    check("post_reset_add", 32'd10, 1'b0);

    // randomized run against the model; expected results flow through exp_q
    hold_r = 32'd10;
    for (int n = 0; n < 400; n++) begin
      v    = ($urandom_range(0, 4) != 0);
      pick = op_list[$urandom_range(0, 16)];
      c    = 22'($urandom & 32'h001F_0000);
      ren  = ($urandom_range(0, 15) == 0);
      if (!ren) c = c | bit_of(pick);
      if ($urandom_range(0, 9) == 0) c = c | bit_of(op_list[$urandom_range(0, 16)]);
      if ($urandom_range(0, 19) == 0) begin c = c & 22'h1F_0000; ren = 1'b0; end
      rd = $urandom;
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h0;
      if (v) begin
        model(c, ren, rd, a, b, exp_r, exp_e);
        hold_r = exp_r;
      end else begin
        exp_r = hold_r;
        exp_e = 1'b0;
      end
      exp_q.push_back(exp_r);
      drive(v, c, ren, rd, a, b);
      check($sformatf("rand_%0d", n), exp_q.pop_front(), exp_e);
    end

    valid_in = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
